// File: rtl/sha256_round_sequencer.sv
// SHA-256 compression sequencer: latches a midstate, loads 16 message words,
// runs ROUNDS rounds (one per clock) with an on-the-fly message schedule, adds
// the midstate back in and holds the digest until the consumer accepts it.
module sha256_round_sequencer #(
    parameter int unsigned ROUNDS = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] midstate,
    input  logic [31:0]  msg_word,
    input  logic         msg_valid,
    output logic         msg_ready,
    output logic [5:0]   round_idx,
    input  logic [31:0]  k_in,
    output logic         busy,
    output logic [255:0] digest,
    output logic         digest_valid,
    input  logic         digest_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_FINAL,
        S_DONE
    } state_t;

    localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

    // Lane 7 holds H0 / a and lane 0 holds H7 / h, so the packed vectors line
    // up directly with the midstate and digest bit order.
    state_t            state_q,  state_d;
    logic [7:0][31:0]  h_q,      h_d;
    logic [7:0][31:0]  v_q,      v_d;
    logic [15:0][31:0] w_q,      w_d;
    logic [3:0]        cnt_q,    cnt_d;
    logic [5:0]        t_q,      t_d;
    logic [7:0][31:0]  digest_q, digest_d;

    logic [31:0] t1;
    logic [31:0] t2;
    logic [31:0] w_next;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection for the load / round / finalise / handshake sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_LOAD;
            S_LOAD:  if (msg_valid && cnt_q == 4'd15) state_d = S_ROUND;
            S_ROUND: if (t_q == LAST_ROUND) state_d = S_FINAL;
            S_FINAL: state_d = S_DONE;
            S_DONE:  if (digest_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the current state.
    always_comb begin
        msg_ready    = (state_q == S_LOAD);
        busy         = (state_q != S_IDLE);
        digest_valid = (state_q == S_DONE);
        round_idx    = t_q;
        digest       = digest_q;
    end

    // Round function terms and next schedule word from the current window.
    always_comb begin
        t1     = v_q[0] + bsig1(v_q[3]) + ((v_q[3] & v_q[2]) ^ (~v_q[3] & v_q[1]))
               + k_in + w_q[0];
        t2     = bsig0(v_q[7]) + ((v_q[7] & v_q[6]) ^ (v_q[7] & v_q[5]) ^ (v_q[6] & v_q[5]));
        w_next = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];
    end

    // Datapath next-state: midstate capture, word loading, rounds, final add.
    always_comb begin
        h_d      = h_q;
        v_d      = v_q;
        w_d      = w_q;
        cnt_d    = cnt_q;
        t_d      = t_q;
        digest_d = digest_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    h_d   = midstate;
                    v_d   = midstate;
                    cnt_d = '0;
                    t_d   = '0;
                end
            end
            S_LOAD: begin
                if (msg_valid) begin
                    w_d[cnt_q] = msg_word;
                    cnt_d      = cnt_q + 4'd1;
                end
            end
            S_ROUND: begin
                // a..h shift one lane down; a and e take the freshly computed sums.
                v_d = {t1 + t2, v_q[7:5], v_q[4] + t1, v_q[3:1]};
                w_d = {w_next, w_q[15:1]};
                t_d = (t_q == LAST_ROUND) ? '0 : t_q + 6'd1;
            end
            S_FINAL: begin
                for (int unsigned i = 0; i < 8; i++) begin
                    digest_d[i] = h_q[i] + v_q[i];
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset discards any partial block and the digest.
    always_ff @(posedge clk) begin
        if (!rst) begin
            h_q      <= '0;
            v_q      <= '0;
            w_q      <= '0;
            cnt_q    <= '0;
            t_q      <= '0;
            digest_q <= '0;
        end else begin
            h_q      <= h_d;
            v_q      <= v_d;
            w_q      <= w_d;
            cnt_q    <= cnt_d;
            t_q      <= t_d;
            digest_q <= digest_d;
        end
    end

endmodule

// File: tb/tb_sha256_round_sequencer.sv
// Scoreboard bench for sha256_round_sequencer: known-answer blocks, handshake
// stalls, mid-run reset, ignored start pulses, latency, and random blocks
// checked against a straightforward SHA-256 compression model.
module tb_sha256_round_sequencer;

    localparam int unsigned ROUNDS = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [255:0] midstate = '0;
    logic [31:0]  msg_word = '0;
    logic         msg_valid = 1'b0;
    logic         msg_ready;
    logic [5:0]   round_idx;
    logic [31:0]  k_in;
    logic         busy;
    logic [255:0] digest;
    logic         digest_valid;
    logic         digest_ready = 1'b1;

    logic [31:0]  K [64];
    logic [255:0] exp_q [$];
    int           vectors = 0;
    int           miscompares = 0;
    int           cyc = 0;
    int           hs_count = 0;
    int           rise_cyc = 0;
    int           last_e = 0;
    logic         prev_valid = 1'b0;

    localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] ABC_DIGEST = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] EMPTY_DIGEST = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

    sha256_round_sequencer #(.ROUNDS(ROUNDS)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .midstate     (midstate),
        .msg_word     (msg_word),
        .msg_valid    (msg_valid),
        .msg_ready    (msg_ready),
        .round_idx    (round_idx),
        .k_in         (k_in),
        .busy         (busy),
        .digest       (digest),
        .digest_valid (digest_valid),
        .digest_ready (digest_ready)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Edge counter used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    // K ROM, combinational from round_idx.
    assign k_in = K[round_idx];

    initial begin
        K = '{
            32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
            32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
            32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
            32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
            32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
            32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
            32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
            32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
        };
    end

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference SHA-256 compression: full 64-entry schedule, then the rounds.
    function automatic logic [255:0] ref_compress(input logic [255:0] mid, input logic [511:0] blk);
        logic [31:0] W [64];
        logic [31:0] H [8];
        logic [31:0] v [8];
        logic [31:0] s0, s1, x1, x2;
        logic [255:0] res;
        for (int t = 0; t < 16; t++) W[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rr(W[t-15], 7) ^ rr(W[t-15], 18) ^ (W[t-15] >> 3);
            s1 = rr(W[t-2], 17) ^ rr(W[t-2], 19) ^ (W[t-2] >> 10);
            W[t] = s1 + W[t-7] + s0 + W[t-16];
        end
        for (int i = 0; i < 8; i++) begin
            H[i] = mid[255 - 32*i -: 32];
            v[i] = H[i];
        end
        for (int t = 0; t < int'(ROUNDS); t++) begin
            x1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + W[t];
            x2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + x1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = x1 + x2;
        end
        for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = H[i] + v[i];
        return res;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic chk_wide(input string name, input logic [255:0] got, input logic [255:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    // Monitor: compare each newly presented digest with the scoreboard head, count handshakes.
    always @(negedge clk) begin
        if (digest_valid && !prev_valid) begin
            rise_cyc = cyc;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_digest: got %h with none required", digest);
            end else begin
                chk_wide("digest", digest, exp_q.pop_front());
            end
        end
        if (digest_valid && digest_ready) hs_count++;
        prev_valid = digest_valid;
    end

    task automatic send_block(input logic [255:0] mid, input logic [511:0] blk,
                              input int gap_mode, input bit pulse_in_load);
        int n;
        n = 0;
        @(posedge clk); #1;
        while (busy && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) chk("idle_timeout", 32'(busy), 32'd0);
        start = 1'b1;
        midstate = mid;
        @(posedge clk); #1;
        start = 1'b0;
        chk("msg_ready_in_load", 32'(msg_ready), 32'd1);
        for (int i = 0; i < 16; i++) begin
            if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
                msg_valid = 1'b0;
                msg_word = $urandom;
                @(posedge clk); #1;
            end
            if (pulse_in_load && i == 5) begin
                start = 1'b1;
                midstate = '0;
            end
            msg_word = blk[511 - 32*i -: 32];
            msg_valid = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        msg_valid = 1'b0;
        msg_word = $urandom;
        last_e = cyc;
        chk("msg_ready_after_load", 32'(msg_ready), 32'd0);
    endtask

    task automatic wait_hs(input bit rand_ready, output int busy_low);
        int hs0;
        int n;
        hs0 = hs_count;
        n = 0;
        busy_low = 0;
        while (hs_count == hs0 && n < 300) begin
            if (rand_ready) digest_ready = ($urandom_range(0, 1) == 1);
            if (!busy) busy_low++;
            @(posedge clk); #1;
            n++;
        end
        if (hs_count == hs0) chk("handshake_timeout", 32'(hs_count - hs0), 32'd1);
        digest_ready = 1'b1;
    endtask

    // Stimulus sequence.
    initial begin
        logic [511:0] abc_blk;
        logic [511:0] empty_blk;
        logic [511:0] rblk;
        logic [255:0] rmid;
        logic [255:0] d0;
        int           bl;
        int           n;
        int           hs_before;

        abc_blk = '0;
        abc_blk[511:480] = 32'h61626380;
        abc_blk[31:0] = 32'h00000018;
        empty_blk = '0;
        empty_blk[511:480] = 32'h80000000;

        // Reset state.
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("reset_msg_ready", 32'(msg_ready), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_digest_valid", 32'(digest_valid), 32'd0);
        chk("reset_round_idx", 32'(round_idx), 32'd0);
        chk_wide("reset_digest", digest, '0);

        // "abc" with round_idx stepping and latency.
        exp_q.push_back(ABC_DIGEST);
        send_block(IV, abc_blk, 0, 1'b0);
        for (int i = 0; i < int'(ROUNDS); i++) begin
            chk("round_idx_step", 32'(round_idx), 32'(i));
            @(posedge clk); #1;
        end
        chk("round_idx_final_wrap", 32'(round_idx), 32'd0);
        wait_hs(1'b0, bl);
        chk("latency", 32'(rise_cyc - last_e), 32'(ROUNDS + 1));

        // Empty message.
        exp_q.push_back(EMPTY_DIGEST);
        send_block(IV, empty_blk, 0, 1'b0);
        wait_hs(1'b0, bl);

        // Gapped words and a held-off consumer.
        exp_q.push_back(ABC_DIGEST);
        digest_ready = 1'b0;
        send_block(IV, abc_blk, 1, 1'b0);
        n = 0;
        while (!digest_valid && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (!digest_valid) chk("digest_valid_timeout", 32'(digest_valid), 32'd1);
        d0 = digest;
        hs_before = hs_count;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(digest_valid), 32'd1);
            chk_wide("hold_digest", digest, d0);
        end
        digest_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("single_handshake", 32'(hs_count - hs_before), 32'd1);
        chk("valid_drop_after_hs", 32'(digest_valid), 32'd0);
        chk_wide("digest_kept_after_hs", digest, ABC_DIGEST);

        // Reset during round 30, then a fresh block.
        send_block(IV, abc_blk, 0, 1'b0);
        n = 0;
        while (round_idx != 6'd30 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reached_round_30", 32'(round_idx), 32'd30);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        chk("midrun_reset_busy", 32'(busy), 32'd0);
        chk("midrun_reset_msg_ready", 32'(msg_ready), 32'd0);
        chk("midrun_reset_valid", 32'(digest_valid), 32'd0);
        chk("midrun_reset_round_idx", 32'(round_idx), 32'd0);
        chk_wide("midrun_reset_digest", digest, '0);
        exp_q.push_back(ABC_DIGEST);
        send_block(IV, abc_blk, 0, 1'b0);
        wait_hs(1'b0, bl);

        // Start pulses during LOAD and ROUND are ignored.
        exp_q.push_back(ABC_DIGEST);
        send_block(IV, abc_blk, 0, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        start = 1'b1;
        midstate = '0;
        @(posedge clk); #1;
        start = 1'b0;
        wait_hs(1'b0, bl);
        chk("busy_held_until_hs", 32'(bl), 32'd0);
        @(posedge clk); #1;
        chk("busy_low_after_hs", 32'(busy), 32'd0);

        // Random midstates and blocks with random gaps and consumer stalls.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 8; i++) rmid[32*i +: 32] = $urandom;
            for (int i = 0; i < 16; i++) rblk[32*i +: 32] = $urandom;
            exp_q.push_back(ref_compress(rmid, rblk));
            send_block(rmid, rblk, 2, 1'b0);
            wait_hs(1'b1, bl);
        end

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit, %0d miscompares so far", miscompares);
        $fatal(1, "time limit");
    end

endmodule
